// File: rtl/tcdm_traffic_gen.sv
// LFSR-driven random TCDM master with req/gnt handshake, response-timing check and statistics.
// Optional write traffic is compiled in with the TCDM_TGEN_WRITE_EN macro (reads only otherwise).
//
// state | meaning
// IDLE  | after reset, waiting for start_i
// RUN   | LFSR advances each cycle, requests drawn against prob_i
// DRAIN | no new requests; waits for the pending grant and last read response
// DONE  | run finished, statistics frozen until the next start_i
module tcdm_traffic_gen #(
  parameter int          AddrWidth   = 32,
  parameter int          DataWidth   = 32,
  parameter int          NumBanks    = 32,
  parameter int          MemAddrBits = 12,
  parameter int          ProbWidth   = 10,
  parameter logic [31:0] LfsrSeed    = 32'hACE1_2345,
  parameter int          CntWidth    = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [CntWidth-1:0]    num_req_i,
  input  logic [ProbWidth:0]     prob_i,
  output logic                   req_o,
  output logic [AddrWidth-1:0]   add_o,
  output logic                   wen_o,
  output logic [DataWidth-1:0]   wdata_o,
  output logic [DataWidth/8-1:0] be_o,
  input  logic                   gnt_i,
  input  logic                   rvld_i,
  input  logic [DataWidth-1:0]   rdata_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [CntWidth-1:0]    issued_cnt_o,
  output logic [CntWidth-1:0]    gnt_cnt_o,
  output logic [CntWidth-1:0]    wait_cnt_o
);

  localparam int AddrWordOff = $clog2(DataWidth / 8);
  localparam int BankBits    = $clog2(NumBanks);
  localparam int SliceW      = MemAddrBits + BankBits;
  localparam logic [31:0]         Taps   = 32'h8020_0003;
  localparam logic [CntWidth-1:0] CntMax = '1;
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                 state;
  logic [31:0]            lfsr;
  logic                   rvld_exp;
  logic [CntWidth-1:0]    issued_cnt, gnt_cnt, wait_cnt;

  logic                   granted, slot_free, draw_hit, run_end;
  logic [31:0]            lfsr_nxt;
  logic [AddrWidth-1:0]   add_nxt;
  logic                   wen_nxt;
  logic [DataWidth-1:0]   wdata_nxt;
  logic [DataWidth/8-1:0] be_nxt;
  logic                   rdata_unused;

  assign granted   = req_o & gnt_i;
  assign slot_free = ~req_o | gnt_i;
  assign draw_hit  = ({1'b0, lfsr[ProbWidth-1:0]} < prob_i);
  assign run_end   = stop_i | (issued_cnt >= num_req_i);
  assign lfsr_nxt  = lfsr[0] ? ((lfsr >> 1) ^ Taps) : (lfsr >> 1);
  assign add_nxt   = AddrWidth'({lfsr[31 -: SliceW], {AddrWordOff{1'b0}}});

`ifdef TCDM_TGEN_WRITE_EN
  localparam int Reps = (DataWidth + 31) / 32;
  assign wen_nxt   = lfsr[0];
  assign wdata_nxt = DataWidth'({Reps{lfsr}});
  assign be_nxt    = '1;
`else
  assign wen_nxt   = 1'b0;
  assign wdata_nxt = '0;
  assign be_nxt    = '0;
`endif

  // Read data content is not checked, only its timing.
  assign rdata_unused = ^rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      lfsr       <= LfsrSeed;
      req_o      <= 1'b0;
      add_o      <= '0;
      wen_o      <= 1'b0;
      wdata_o    <= '0;
      be_o       <= '0;
      rvld_exp   <= 1'b0;
      err_o      <= 1'b0;
      issued_cnt <= '0;
      gnt_cnt    <= '0;
      wait_cnt   <= '0;
    end else begin
      rvld_exp <= granted & ~wen_o;
      if (rvld_i != rvld_exp) err_o <= 1'b1;
      if (state == RUN || state == DRAIN) begin
        if (granted && gnt_cnt != CntMax) gnt_cnt <= gnt_cnt + CntOne;
        if (req_o && !gnt_i && wait_cnt != CntMax) wait_cnt <= wait_cnt + CntOne;
      end
      if (granted) req_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state      <= RUN;
            issued_cnt <= '0;
            gnt_cnt    <= '0;
            wait_cnt   <= '0;
            err_o      <= 1'b0;
          end
        end
        RUN: begin
          lfsr <= lfsr_nxt;
          if (run_end) begin
            state <= DRAIN;
          end else if (slot_free && draw_hit) begin
            // A granted cycle may load the next request back-to-back.
            req_o   <= 1'b1;
            add_o   <= add_nxt;
            wen_o   <= wen_nxt;
            wdata_o <= wdata_nxt;
            be_o    <= be_nxt;
            if (issued_cnt != CntMax) issued_cnt <= issued_cnt + CntOne;
          end
        end
        DRAIN: begin
          if (!req_o && !rvld_exp) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o       = (state == RUN) || (state == DRAIN);
  assign done_o       = (state == DONE);
  assign issued_cnt_o = issued_cnt;
  assign gnt_cnt_o    = gnt_cnt;
  assign wait_cnt_o   = wait_cnt;

endmodule

// File: tb/tb_tcdm_traffic_gen.sv
// Self-checking bench for tcdm_traffic_gen: directed scenarios plus randomized runs
// compared cycle by cycle against a behavioural model of the run/draw/handshake rules.
module tb_tcdm_traffic_gen;
  localparam int AW = 32, DW = 32, PW = 10, CW = 32;
  localparam logic [31:0] SEED = 32'hACE1_2345;
  localparam int SLICE = 17, WOFF = 2;

  logic clk_i = 1'b0;
  logic rst_i, start_i, stop_i, gnt_i, rvld_i;
  logic [CW-1:0] num_req_i;
  logic [PW:0] prob_i;
  logic req_o, wen_o, busy_o, done_o, err_o;
  logic [AW-1:0] add_o;
  logic [DW-1:0] wdata_o, rdata_i;
  logic [DW/8-1:0] be_o;
  logic [CW-1:0] issued_cnt_o, gnt_cnt_o, wait_cnt_o;

  tcdm_traffic_gen dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .num_req_i(num_req_i), .prob_i(prob_i), .req_o(req_o), .add_o(add_o),
    .wen_o(wen_o), .wdata_o(wdata_o), .be_o(be_o), .gnt_i(gnt_i),
    .rvld_i(rvld_i), .rdata_i(rdata_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .issued_cnt_o(issued_cnt_o), .gnt_cnt_o(gnt_cnt_o),
    .wait_cnt_o(wait_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;
  bit auto_rvld;

  // Reference model: 0 idle, 1 running, 2 draining, 3 finished
  int          m_st;
  logic [31:0] m_lfsr, m_add;
  bit          m_req, m_rexp, m_err, m_wen;
  longint      m_issued, m_gnt, m_wait;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  function automatic logic [31:0] lfsr_adv(input int n);
    logic [31:0] v = SEED;
    for (int i = 0; i < n; i++) v = lfsr_next(v);
    return v;
  endfunction

  function automatic logic [31:0] addr_of(input logic [31:0] v);
    return (v >> (32 - SLICE)) << WOFF;
  endfunction

  task automatic tick();
    bit rd_grant, granted, wn, rq, rx, er;
    int st;
    logic [31:0] lf, ad;
    longint is, gn, wt;
    rd_grant = req_o && gnt_i && !wen_o;
    granted = m_req && gnt_i;
    st = m_st; lf = m_lfsr; ad = m_add; rq = m_req; rx = m_rexp; er = m_err;
    wn = m_wen; is = m_issued; gn = m_gnt; wt = m_wait;
    if (rst_i) begin
      st = 0; lf = SEED; ad = 0; rq = 0; rx = 0; er = 0; wn = 0; is = 0; gn = 0; wt = 0;
    end else begin
      if (rvld_i !== m_rexp) er = 1;
      rx = granted && !m_wen;
      if (st == 1 || st == 2) begin
        if (granted) gn++;
        else if (m_req) wt++;
      end
      if (granted) rq = 0;
      if ((st == 0 || st == 3) && start_i) begin
        st = 1; is = 0; gn = 0; wt = 0; er = 0;
      end else if (st == 1) begin
        lf = lfsr_next(m_lfsr);
        if (stop_i || m_issued >= num_req_i) st = 2;
        else if ((!m_req || granted) && (m_lfsr % (1 << PW)) < prob_i) begin
          rq = 1; ad = addr_of(m_lfsr); is++;
`ifdef TCDM_TGEN_WRITE_EN
          wn = m_lfsr[0];
`else
          wn = 0;
`endif
        end
      end else if (st == 2 && !m_req && !m_rexp) begin
        st = 3;
      end
    end
    @(posedge clk_i);
    m_st = st; m_lfsr = lf; m_add = ad; m_req = rq; m_rexp = rx; m_err = er;
    m_wen = wn; m_issued = is; m_gnt = gn; m_wait = wt;
    #1;
    if (auto_rvld) rvld_i = rd_grant;
  endtask

  task automatic do_reset();
    start_i = 0; stop_i = 0; gnt_i = 0; rvld_i = 0; auto_rvld = 1;
    rst_i = 1; tick(); tick(); rst_i = 0;
  endtask

  task automatic pulse_start();
    start_i = 1; tick(); start_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req_o !== 1'b0 || add_o !== '0) begin errors++;
      $display("FAIL reset_bus req=%b add=%h required 0/0", req_o, add_o); end
    checks++; if (wen_o !== 1'b0 || wdata_o !== '0 || be_o !== '0) begin errors++;
      $display("FAIL reset_payload wen=%b wdata=%h be=%h required 0", wen_o, wdata_o, be_o); end
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin errors++;
      $display("FAIL reset_status busy=%b done=%b err=%b required 0", busy_o, done_o, err_o); end
    checks++; if (issued_cnt_o !== '0 || gnt_cnt_o !== '0 || wait_cnt_o !== '0) begin errors++;
      $display("FAIL reset_counters %0d %0d %0d required 0", issued_cnt_o, gnt_cnt_o, wait_cnt_o); end
  endtask

  task automatic test_full_prob();
    int high = 0, run = 0, best = 0, bad_addr = 0;
    bit fin = 0;
    do_reset();
    prob_i = 11'd1024; num_req_i = 100; gnt_i = 1;
    pulse_start();
    for (int i = 0; i < 300 && !fin; i++) begin
      tick();
      if (req_o) begin
        if (add_o !== addr_of(lfsr_adv(high))) bad_addr++;
        high++; run++; if (run > best) best = run;
      end else run = 0;
      fin = done_o;
    end
    gnt_i = 0;
    checks++; if (!fin) begin errors++; $display("FAIL full_done done=%b required 1 (timeout)", done_o); end
    checks++; if (best != 100 || high != 100) begin errors++;
      $display("FAIL full_req_run consecutive=%0d total=%0d required 100", best, high); end
    checks++; if (bad_addr != 0) begin errors++; $display("FAIL full_addr bad=%0d required 0", bad_addr); end
    checks++; if (issued_cnt_o !== 100 || gnt_cnt_o !== 100 || wait_cnt_o !== 0) begin errors++;
      $display("FAIL full_counters issued=%0d gnt=%0d wait=%0d required 100/100/0",
               issued_cnt_o, gnt_cnt_o, wait_cnt_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL full_err err=%b required 0", err_o); end
  endtask

  task automatic test_zero_prob();
    int req_seen = 0, idle_busy = 0;
    bit fin = 0;
    do_reset();
    prob_i = 0; num_req_i = 10; gnt_i = 1;
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (req_o) req_seen++;
      if (!busy_o || done_o) idle_busy++;
    end
    checks++; if (idle_busy != 0) begin errors++; $display("FAIL zero_stays_run left_run_cycles=%0d required 0", idle_busy); end
    stop_i = 1; tick(); stop_i = 0;
    for (int i = 0; i < 20 && !fin; i++) begin tick(); fin = done_o; end
    gnt_i = 0;
    checks++; if (!fin) begin errors++; $display("FAIL zero_done done=%b required 1", done_o); end
    checks++; if (req_seen != 0 || issued_cnt_o !== 0) begin errors++;
      $display("FAIL zero_issued req_cycles=%0d issued=%0d required 0", req_seen, issued_cnt_o); end
  endtask

  task automatic test_wait_stable();
    logic [AW-1:0] first;
    int unstable = 0;
    bit fin = 0;
    do_reset();
    prob_i = 11'd1024; num_req_i = 4; gnt_i = 0;
    pulse_start();
    tick();
    first = add_o;
    checks++; if (req_o !== 1'b1 || first !== addr_of(SEED)) begin errors++;
      $display("FAIL wait_first req=%b add=%h required 1/%h", req_o, first, addr_of(SEED)); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!req_o || add_o !== first) unstable++;
    end
    gnt_i = 1; tick();
    checks++; if (unstable != 0) begin errors++; $display("FAIL wait_stable unstable=%0d required 0", unstable); end
    checks++; if (wait_cnt_o !== 5 || gnt_cnt_o !== 1) begin errors++;
      $display("FAIL wait_counts wait=%0d gnt=%0d required 5/1", wait_cnt_o, gnt_cnt_o); end
    for (int i = 0; i < 30 && !fin; i++) begin tick(); fin = done_o; end
    gnt_i = 0;
    checks++; if (!fin || issued_cnt_o !== 4 || gnt_cnt_o !== 4 || wait_cnt_o !== 5 || err_o !== 1'b0) begin errors++;
      $display("FAIL wait_final done=%b issued=%0d gnt=%0d wait=%0d err=%b required 1/4/4/5/0",
               done_o, issued_cnt_o, gnt_cnt_o, wait_cnt_o, err_o); end
  endtask

  task automatic test_stop_hold();
    logic [AW-1:0] held;
    int dropped = 0;
    bit fin = 0;
    do_reset();
    prob_i = 11'd1024; num_req_i = 50; gnt_i = 0;
    pulse_start();
    tick();
    held = add_o;
    stop_i = 1; tick(); stop_i = 0;
    for (int i = 0; i < 2; i++) begin
      if (!req_o || add_o !== held || done_o) dropped++;
      tick();
    end
    checks++; if (dropped != 0 || req_o !== 1'b1 || busy_o !== 1'b1) begin errors++;
      $display("FAIL stop_hold dropped=%0d req=%b busy=%b required 0/1/1", dropped, req_o, busy_o); end
    gnt_i = 1; tick(); gnt_i = 0;
    for (int i = 0; i < 10 && !fin; i++) begin tick(); fin = done_o; end
    checks++; if (!fin || req_o !== 1'b0) begin errors++; $display("FAIL stop_done done=%b req=%b required 1/0", done_o, req_o); end
    checks++; if (issued_cnt_o !== 1 || gnt_cnt_o !== 1 || wait_cnt_o !== 3) begin errors++;
      $display("FAIL stop_counts issued=%0d gnt=%0d wait=%0d required 1/1/3", issued_cnt_o, gnt_cnt_o, wait_cnt_o); end
  endtask

  task automatic test_err();
    bit fin = 0;
    int lost = 0;
    do_reset();
    auto_rvld = 0; prob_i = 0; num_req_i = 10;
    pulse_start();
    tick(); tick();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_clean err=%b required 0", err_o); end
    rvld_i = 1; tick(); rvld_i = 0;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_spurious err=%b required 1", err_o); end
    stop_i = 1; tick(); stop_i = 0;
    for (int i = 0; i < 10 && !fin; i++) begin tick(); if (!err_o) lost++; fin = done_o; end
    checks++; if (lost != 0 || !fin) begin errors++; $display("FAIL err_sticky cleared_cycles=%0d done=%b required 0/1", lost, done_o); end
    prob_i = 11'd1024; num_req_i = 2; gnt_i = 1;
    pulse_start();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_start_clear err=%b required 0", err_o); end
    fin = 0;
    for (int i = 0; i < 20 && !fin; i++) begin tick(); fin = done_o; end
    gnt_i = 0;
    checks++; if (err_o !== 1'b1 || !fin) begin errors++;
      $display("FAIL err_missing_rvld err=%b done=%b required 1/1", err_o, done_o); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    prob_i = 11'd1024; num_req_i = 20; gnt_i = 0;
    pulse_start();
    tick(); tick();
    checks++; if (req_o !== 1'b1 || wait_cnt_o !== 1) begin errors++;
      $display("FAIL rst_pre req=%b wait=%0d required 1/1", req_o, wait_cnt_o); end
    rst_i = 1; tick(); rst_i = 0;
    checks++; if (req_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin errors++;
      $display("FAIL rst_mid_state req=%b busy=%b done=%b required 0/0/0", req_o, busy_o, done_o); end
    checks++; if (issued_cnt_o !== 0 || gnt_cnt_o !== 0 || wait_cnt_o !== 0) begin errors++;
      $display("FAIL rst_mid_cnt %0d %0d %0d required 0", issued_cnt_o, gnt_cnt_o, wait_cnt_o); end
    num_req_i = 1; gnt_i = 1;
    pulse_start();
    tick();
    checks++; if (req_o !== 1'b1 || add_o !== addr_of(SEED)) begin errors++;
      $display("FAIL rst_lfsr_seed add=%h required %h", add_o, addr_of(SEED)); end
    for (int i = 0; i < 5; i++) tick();
    gnt_i = 0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int diff = 0;
      bit fin = 0;
      do_reset();
      prob_i = (it == 0) ? 11'd1024 : 11'($urandom_range(60, 1023));
      num_req_i = (it == 1) ? 0 : $urandom_range(1, 30);
      pulse_start();
      for (int c = 0; c < 3000 && !fin; c++) begin
        gnt_i = ($urandom_range(0, 99) < 60);
        stop_i = (it >= 4) && ($urandom_range(0, 99) < 2);
        tick();
        stop_i = 0;
        if (req_o !== m_req || (m_req && add_o !== m_add[AW-1:0])) diff++;
        if (busy_o !== (m_st == 1 || m_st == 2) || done_o !== (m_st == 3) || err_o !== m_err) diff++;
        fin = done_o;
      end
      gnt_i = 0;
      checks++; if (diff != 0 || !fin) begin errors++;
        $display("FAIL rand%0d_trace diffs=%0d done=%b required 0/1", it, diff, done_o); end
      checks++; if (issued_cnt_o !== CW'(m_issued) || gnt_cnt_o !== CW'(m_gnt) || wait_cnt_o !== CW'(m_wait)) begin errors++;
        $display("FAIL rand%0d_counts issued=%0d gnt=%0d wait=%0d required %0d/%0d/%0d", it,
                 issued_cnt_o, gnt_cnt_o, wait_cnt_o, m_issued, m_gnt, m_wait); end
      checks++; if (err_o !== 1'b0 || (it < 4 && issued_cnt_o !== num_req_i)) begin errors++;
        $display("FAIL rand%0d_end err=%b issued=%0d required 0/%0d", it, err_o, issued_cnt_o, num_req_i); end
    end
  endtask

  initial begin
    rst_i = 1; start_i = 0; stop_i = 0; gnt_i = 0; rvld_i = 0; auto_rvld = 1;
    num_req_i = 0; prob_i = 0; rdata_i = 32'h5A5A_1234;
    test_reset();
    test_full_prob();
    test_zero_prob();
    test_wait_stable();
    test_stop_hold();
    test_err();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
